oled_spi_tx: RTL and testbench

- Byte-level SPI transmitter for the SSD1306 panel. It sits directly downstream of the SSD1306 init/step sequencer.
- The sequencer pushes {dc, byte} commands into a small internal FIFO. This block serialises each byte MSB-first in SPI mode 0 and drives oled_sclk, oled_sdin, oled_dc and chip-select.
- It replaces the free-running SPI core with an explicit valid/ready handshake and a per-byte completion pulse.

---
 rtl/oled_spi_tx.sv | 173 +++++++++++++++++
 tb/tb_oled_spi_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/oled_spi_tx.sv
// Byte-level SPI (mode 0) transmitter for the SSD1306 panel.
// A small {dc, byte} FIFO feeds a phase engine that drives sclk/sdin/dc/cs_n.
module oled_spi_tx #(
  parameter int CLK_DIV    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_data,
  input  logic                          in_dc,
  output logic                          oled_sclk,
  output logic                          oled_sdin,
  output logic                          oled_dc,
  output logic                          oled_cs_n,
  output logic                          byte_done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic          push;
  logic          pop;
  logic          fifo_empty;
  logic          head_dc;
  logic [7:0]    head_data;

  logic [2:0]    state;
  logic [7:0]    div_cnt;
  logic [2:0]    bit_cnt;
  logic [6:0]    shreg;
  logic          last_low;
  logic          phase_end;

  assign in_ready   = (level != FULL_LVL);
  assign push       = in_valid && in_ready;
  assign fifo_empty = (level == '0);
  assign head_dc    = mem[rd_ptr][8];
  assign head_data  = mem[rd_ptr][7:0];
  assign fifo_level = level;
  assign busy       = (state != S_IDLE) || !fifo_empty;
  assign phase_end  = (div_cnt == DIV_LAST);

  // Pop points: IDLE, the end of a byte when dc matches (back-to-back),
  // and the last GAP cycle so cs_n stays high for exactly CLK_DIV cycles.
  always_comb begin
    pop = 1'b0;
    case (state)
      S_IDLE:  pop = !fifo_empty;
      S_LOW:   pop = phase_end && last_low && !fifo_empty && (head_dc == oled_dc);
      S_GAP:   pop = phase_end && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_dc, in_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Phase engine; a pop anywhere overrides the case and starts a new byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      last_low  <= 1'b0;
      oled_sclk <= 1'b0;
      oled_sdin <= 1'b0;
      oled_dc   <= 1'b0;
      oled_cs_n <= 1'b1;
      byte_done <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      case (state)
        S_SETUP: begin
          if (phase_end) begin
            div_cnt   <= '0;
            oled_sclk <= 1'b1;
            state     <= S_HIGH;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            div_cnt   <= '0;
            oled_sclk <= 1'b0;
            state     <= S_LOW;
            if (bit_cnt != 3'd7) begin
              oled_sdin <= shreg[6];
              shreg     <= {shreg[5:0], 1'b0};
              bit_cnt   <= bit_cnt + 3'd1;
            end else begin
              last_low <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_LOW: begin
          if (phase_end) begin
            div_cnt <= '0;
            if (last_low) begin
              byte_done <= 1'b1;
              last_low  <= 1'b0;
              oled_cs_n <= 1'b1;
              oled_sdin <= 1'b0;
              state     <= S_GAP;
            end else begin
              oled_sclk <= 1'b1;
              state     <= S_HIGH;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            div_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (pop) begin
        shreg     <= head_data[6:0];
        oled_sdin <= head_data[7];
        oled_dc   <= head_dc;
        oled_cs_n <= 1'b0;
        oled_sclk <= 1'b0;
        bit_cnt   <= '0;
        last_low  <= 1'b0;
        div_cnt   <= '0;
        state     <= S_SETUP;
      end
    end
  end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed bench for oled_spi_tx: one instance at CLK_DIV=2, one at CLK_DIV=1,
// with negedge monitors that record captured bits, cs_n runs and byte_done times.
module tb_oled_spi_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       in_valid = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_dc    = 1'b0;
  logic       in_ready, sclk, sdin, dc, cs_n, byte_done, busy;
  logic [2:0] level;

  logic       in_valid1 = 1'b0;
  logic [7:0] in_data1  = 8'h00;
  logic       in_dc1    = 1'b0;
  logic       in_ready1, sclk1, sdin1, dc1, cs_n1, byte_done1, busy1;
  logic [2:0] level1;

  oled_spi_tx #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_dc(in_dc), .oled_sclk(sclk), .oled_sdin(sdin),
    .oled_dc(dc), .oled_cs_n(cs_n), .byte_done(byte_done), .busy(busy),
    .fifo_level(level)
  );

  oled_spi_tx #(.CLK_DIV(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data1), .in_dc(in_dc1), .oled_sclk(sclk1), .oled_sdin(sdin1),
    .oled_dc(dc1), .oled_cs_n(cs_n1), .byte_done(byte_done1), .busy(busy1),
    .fifo_level(level1)
  );

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  logic bits[$];
  int   csfall[$];
  int   bd[$];
  int   runs[$];
  int   rises = 0, cs_bad = 0, dc_bad = 0, rdy_bad = 0, max_lvl = 0;
  int   busy_fall = 0, run = 0;
  logic p_sclk = 1'b0, p_cs = 1'b1, p_dc = 1'b0, p_busy = 1'b0;

  logic bits1[$];
  int   rcyc1[$];
  int   csfall1[$];
  int   bd1[$];
  logic p_sclk1 = 1'b0, p_cs1 = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (sclk && !p_sclk) begin
      bits.push_back(sdin);
      rises++;
      if (cs_n) cs_bad++;
    end
    if (!cs_n && p_cs) begin
      csfall.push_back(cyc);
      runs.push_back(run);
    end
    run = cs_n ? run + 1 : 0;
    if (byte_done) bd.push_back(cyc);
    if (dc != p_dc && !cs_n && !p_cs) dc_bad++;
    if (in_ready != (level != 3'd4)) rdy_bad++;
    if (int'(level) > max_lvl) max_lvl = int'(level);
    if (!busy && p_busy) busy_fall = cyc;
    p_sclk = sclk; p_cs = cs_n; p_dc = dc; p_busy = busy;

    if (sclk1 && !p_sclk1) begin
      bits1.push_back(sdin1);
      rcyc1.push_back(cyc);
    end
    if (!cs_n1 && p_cs1) csfall1.push_back(cyc);
    if (byte_done1) bd1.push_back(cyc);
    p_sclk1 = sclk1; p_cs1 = cs_n1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one entry and hold it until accepted; entered and left on a negedge.
  task automatic applyStimulus(input logic [7:0] d, input logic d_c);
    int n = 0;
    in_data  = d;
    in_dc    = d_c;
    in_valid = 1'b1;
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("push_timeout", 64'(n < 500), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, 64'(n < 2000), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic clearMon();
    bits.delete(); csfall.delete(); bd.delete(); runs.delete();
    rises = 0; cs_bad = 0; dc_bad = 0; rdy_bad = 0; max_lvl = 0;
  endtask

  function automatic logic [63:0] packBits(input int from, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++)
      v = {v[62:0], (from + i < bits.size()) ? bits[from + i] : 1'b0};
    return v;
  endfunction

  function automatic int qAt(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1000;
  endfunction

  initial begin
    logic [63:0] v1;
    int n;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_sclk",  64'(sclk), 64'd0);
    checkOutput("rst_sdin",  64'(sdin), 64'd0);
    checkOutput("rst_cs_n",  64'(cs_n), 64'd1);
    checkOutput("rst_busy",  64'(busy), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single command byte 0xAF
    $display("[TB] single command byte");
    clearMon();
    applyStimulus(8'hAF, 1'b0);
    waitIdle("t1_idle_timeout");
    checkOutput("t1_rises",   64'(rises), 64'd8);
    checkOutput("t1_bits",    packBits(0, 8), 64'hAF);
    checkOutput("t1_cs_bad",  64'(cs_bad), 64'd0);
    checkOutput("t1_bd_cnt",  64'(bd.size()), 64'd1);
    checkOutput("t1_latency", 64'(qAt(bd, 0) - qAt(csfall, 0)), 64'd34);
    checkOutput("t1_gap",     64'(busy_fall - qAt(bd, 0)), 64'd2);
    checkOutput("t1_cs_end",  64'(cs_n), 64'd1);

    // Back-to-back data bytes
    $display("[TB] back-to-back data");
    clearMon();
    applyStimulus(8'h55, 1'b1);
    applyStimulus(8'hAA, 1'b1);
    waitIdle("t2_idle_timeout");
    checkOutput("t2_rises",  64'(rises), 64'd16);
    checkOutput("t2_bits",   packBits(0, 16), 64'h55AA);
    checkOutput("t2_cs_fall", 64'(csfall.size()), 64'd1);
    checkOutput("t2_bd_cnt", 64'(bd.size()), 64'd2);
    checkOutput("t2_bd_gap", 64'(qAt(bd, 1) - qAt(bd, 0)), 64'd34);
    checkOutput("t2_dc",     64'(dc), 64'd1);

    // D/C switch forces a cs_n gap
    $display("[TB] dc switch");
    clearMon();
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hFF, 1'b1);
    waitIdle("t3_idle_timeout");
    checkOutput("t3_bits",    packBits(0, 16), 64'h00FF);
    checkOutput("t3_cs_fall", 64'(csfall.size()), 64'd2);
    checkOutput("t3_gap_len", 64'(qAt(runs, 1)), 64'd2);
    checkOutput("t3_dc_bad",  64'(dc_bad), 64'd0);
    checkOutput("t3_dc_end",  64'(dc), 64'd1);

    // FIFO full with in_valid held across six bytes
    $display("[TB] fifo full");
    clearMon();
    applyStimulus(8'h11, 1'b0);
    applyStimulus(8'h22, 1'b0);
    applyStimulus(8'h33, 1'b0);
    applyStimulus(8'h44, 1'b0);
    applyStimulus(8'h55, 1'b0);
    applyStimulus(8'h66, 1'b0);
    waitIdle("t4_idle_timeout");
    checkOutput("t4_max_level", 64'(max_lvl), 64'd4);
    checkOutput("t4_ready_bad", 64'(rdy_bad), 64'd0);
    checkOutput("t4_rises",     64'(rises), 64'd48);
    checkOutput("t4_bits",      packBits(0, 48), 64'h0000_1122_3344_5566);
    checkOutput("t4_bd_cnt",    64'(bd.size()), 64'd6);
    checkOutput("t4_level_end", 64'(level), 64'd0);

    // Reset mid-byte, with a second entry still queued
    $display("[TB] reset mid-byte");
    clearMon();
    applyStimulus(8'hC3, 1'b0);
    applyStimulus(8'h3C, 1'b0);
    n = 0;
    while (rises < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t5_wait_timeout", 64'(n < 500), 64'd1);
    checkOutput("t5_cs_before", 64'(cs_n), 64'd0);
    #2 rst = 1'b1;
    #1;
    checkOutput("t5_rst_sclk",  64'(sclk), 64'd0);
    checkOutput("t5_rst_cs_n",  64'(cs_n), 64'd1);
    checkOutput("t5_rst_sdin",  64'(sdin), 64'd0);
    checkOutput("t5_rst_busy",  64'(busy), 64'd0);
    checkOutput("t5_rst_level", 64'(level), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    checkOutput("t5_no_rises", 64'(rises), 64'd3);
    checkOutput("t5_no_cs",    64'(csfall.size()), 64'd1);

    // Minimum divider instance
    $display("[TB] clk_div 1");
    in_data1  = 8'h81;
    in_dc1    = 1'b0;
    in_valid1 = 1'b1;
    @(negedge clk);
    in_valid1 = 1'b0;
    n = 0;
    while (busy1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_idle_timeout", 64'(n < 200), 64'd1);
    repeat (3) @(negedge clk);
    v1 = '0;
    for (int i = 0; i < bits1.size(); i++) v1 = {v1[62:0], bits1[i]};
    checkOutput("t6_rises",   64'(bits1.size()), 64'd8);
    checkOutput("t6_bits",    v1, 64'h81);
    checkOutput("t6_span",    64'(qAt(rcyc1, 7) - qAt(rcyc1, 0)), 64'd14);
    checkOutput("t6_latency", 64'(qAt(bd1, 0) - qAt(csfall1, 0)), 64'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
